// File: rtl/rotate_sequencer.sv
// rotate_sequencer: multi-cycle ROL/ROR/RCL/RCR engine, one single-bit rotate per clock.
module rotate_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [7:0]  count,
    input  logic [1:0]  op,
    input  logic        Cin,
    output logic [15:0] R,
    output logic        CF,
    output logic        OF,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] w_q, w_d;
    logic        c_q, c_d;
    logic [7:0]  k_q, k_d;
    logic [1:0]  op_q, op_d;
    logic        a15s_q, a15s_d;
    logic        nz_q, nz_d;
    logic        accept, run;
    logic [15:0] step_w;
    logic        step_c;

    assign accept = start && (state_q != RUN);
    assign run    = (state_q == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            op_q    <= '0;
            a15s_q  <= 1'b0;
            nz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            c_q     <= c_d;
            k_q     <= k_d;
            op_q    <= op_d;
            a15s_q  <= a15s_d;
            nz_q    <= nz_d;
        end
    end

    always_comb begin
        state_d = accept ? ((count != 8'd0) ? RUN : DONE)
                : run    ? ((k_q == 8'd1) ? DONE : RUN)
                :          IDLE;
    end

    // Single-bit step; the carry-through forms treat {C,W} as a 17-bit ring.
    always_comb begin
        step_w = w_q;
        step_c = c_q;
        case (op_q)
            2'b00:   begin step_w = {w_q[14:0], w_q[15]}; step_c = w_q[15]; end
            2'b01:   begin step_w = {w_q[0], w_q[15:1]};  step_c = w_q[0];  end
            2'b10:   begin step_w = {w_q[14:0], c_q};     step_c = w_q[15]; end
            default: begin step_w = {c_q, w_q[15:1]};     step_c = w_q[0];  end
        endcase
    end

    always_comb begin
        w_d    = accept ? A     : run ? step_w      : w_q;
        c_d    = accept ? Cin   : run ? step_c      : c_q;
        k_d    = accept ? count : run ? k_q - 8'd1  : k_q;
        op_d   = accept ? op    : op_q;
        a15s_d = accept ? A[15] : a15s_q;
        nz_d   = accept ? (count != 8'd0) : nz_q;
    end

    always_comb begin
        R    = w_q;
        CF   = c_q;
        OF   = nz_q & (a15s_q ^ w_q[15]);
        busy = run;
        done = (state_q == DONE);
    end
endmodule

// File: tb/tb_rotate_sequencer.sv
// tb_rotate_sequencer: table vectors, corner sequences and randomized ops vs. an arithmetic rotate model.
module tb_rotate_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, Cin;
    logic [15:0] A, R;
    logic [7:0]  count;
    logic [1:0]  op;
    logic        CF, OF, busy, done;
    int          n_checks = 0;
    int          n_errors = 0;

    rotate_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .count(count), .op(op), .Cin(Cin),
        .R(R), .CF(CF), .OF(OF), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [7:0]  cnt;
        logic        cin;
        logic [15:0] r;
        logic        cf;
        logic        of;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole-operation result: rotate by count mod width (16, or 17 through carry).
    function automatic logic [17:0] model(input logic [1:0] o, input logic [15:0] a,
                                          input logic [7:0] c, input logic ci);
        logic [33:0] v, y;
        logic [15:0] r;
        logic        cf;
        int          m;
        if (!o[1]) begin
            m  = int'(c) % 16;
            v  = {18'b0, a};
            y  = o[0] ? ((v >> m) | (v << (16 - m))) : ((v << m) | (v >> (16 - m)));
            r  = y[15:0];
            cf = (c == 8'd0) ? ci : (o[0] ? r[15] : r[0]);
        end else begin
            m  = int'(c) % 17;
            v  = {17'b0, ci, a};
            y  = o[0] ? ((v >> m) | (v << (17 - m))) : ((v << m) | (v >> (17 - m)));
            r  = y[15:0];
            cf = y[16];
        end
        return {r, cf, (c != 8'd0) && (a[15] ^ r[15])};
    endfunction

    // Inputs are scrambled while the op runs; they must not affect the result.
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [7:0] c,
                          input logic ci, output int lat, output logic busy_ok);
        op = o; A = a; count = c; Cin = ci; start = 1'b1;
        tick;
        start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 300) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            A = 16'($urandom); count = 8'($urandom); op = 2'($urandom); Cin = 1'($urandom);
            tick;
            lat++;
        end
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [1:0] o, input logic [15:0] a,
                            input logic [7:0] c, input logic ci);
        int          lat;
        logic        bok;
        logic [17:0] e;
        e = model(o, a, c, ci);
        run_op(o, a, c, ci, lat, bok);
        chk({name, ".lat"}, lat, int'(c) + 1);
        chk({name, ".R"}, R, e[17:2]);
        chk({name, ".CF"}, CF, e[1]);
        chk({name, ".OF"}, OF, e[0]);
        chk({name, ".busy"}, bok, 1'b1);
    endtask

    initial begin
        int          lat, gap;
        logic        bok, saw_done;
        logic [17:0] e;
        logic [1:0]  ro;
        logic [15:0] ra;
        logic [7:0]  rc;
        logic        rci;

        vecs[0] = '{2'b00, 16'h8001, 8'd1,   1'b0, 16'h0003, 1'b1, 1'b1, 2};
        vecs[1] = '{2'b11, 16'h0001, 8'd2,   1'b0, 16'h8000, 1'b0, 1'b1, 3};
        vecs[2] = '{2'b01, 16'h1234, 8'd16,  1'b0, 16'h1234, 1'b0, 1'b0, 17};
        vecs[3] = '{2'b10, 16'hABCD, 8'd17,  1'b1, 16'hABCD, 1'b1, 1'b0, 18};
        vecs[4] = '{2'b10, 16'h5A5A, 8'd0,   1'b1, 16'h5A5A, 1'b1, 1'b0, 1};
        vecs[5] = '{2'b01, 16'h0001, 8'd1,   1'b0, 16'h8000, 1'b1, 1'b1, 2};
        vecs[6] = '{2'b00, 16'h0001, 8'd255, 1'b0, 16'h8000, 1'b0, 1'b1, 256};
        vecs[7] = '{2'b11, 16'h8000, 8'd255, 1'b1, 16'h8000, 1'b1, 1'b0, 256};

        rst = 1'b1; start = 1'b1; A = 16'hFFFF; count = 8'd3; op = 2'b00; Cin = 1'b1;
        tick;
        tick;
        chk("reset.R", R, 16'h0);
        chk("reset.flags", {CF, OF, busy, done}, 4'b0000);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].cnt, vecs[i].cin, lat, bok);
            chk($sformatf("vec%0d.lat", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d.R", i), R, vecs[i].r);
            chk($sformatf("vec%0d.CF", i), CF, vecs[i].cf);
            chk($sformatf("vec%0d.OF", i), OF, vecs[i].of);
            chk($sformatf("vec%0d.busy", i), bok, 1'b1);
            tick;
            chk($sformatf("vec%0d.hold", i), {R, CF, OF, done}, {vecs[i].r, vecs[i].cf, vecs[i].of, 1'b0});
        end

        // Start re-asserted with different operands during RUN must be ignored.
        op = 2'b00; A = 16'h1234; count = 8'd5; Cin = 1'b0; start = 1'b1;
        tick;
        A = 16'hFFFF; op = 2'b11; count = 8'd3; Cin = 1'b1;
        tick; tick; tick;
        start = 1'b0;
        lat = 4;
        while (!done && lat < 300) begin tick; lat++; end
        e = model(2'b00, 16'h1234, 8'd5, 1'b0);
        chk("ignore.lat", lat, 6);
        chk("ignore.res", {R, CF, OF}, e);
        // Back-to-back: start issued during the DONE cycle.
        check_op("b2b", 2'b11, 16'hFFFF, 8'd3, 1'b1);

        // Reset in place of step 3 of a count=10 operation.
        op = 2'b00; A = 16'hF00F; count = 8'd10; Cin = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst.R", R, 16'h0);
        chk("midrst.flags", {CF, OF, busy, done}, 4'b0000);
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin tick; if (done) saw_done = 1'b1; end
        chk("midrst.nodone", saw_done, 1'b0);
        check_op("afterrst", 2'b10, 16'h8421, 8'd9, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom);
            ra  = 16'($urandom);
            rc  = (i % 8 == 7) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 40));
            rci = 1'($urandom);
            check_op($sformatf("rnd%0d", i), ro, ra, rc, rci);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
